// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment digit scanner. It drives the digit decoder select/enable
// and presents the selected hex nibble to the segment encoder. A blanking interval at
// the start of each slot prevents ghosting. Leading zeros can be suppressed. The value
// is snapshotted once per frame so that a frame is always displayed coherently.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              dig_idx,
  output logic                    dig_en,
  output logic [3:0]              nibble,
  output logic                    frame_tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] SlotLast = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankVal = CntW'(BLANK_CYCLES);
  localparam logic [3:0]      LastIdx  = 4'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                  state;
  logic [CntW-1:0]         slot_cnt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    supp;
  logic                    past_blank;

  // Scan FSM: slot timing, digit stepping, and the frame-start snapshot and tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      slot_cnt   <= '0;
      dig_idx    <= '0;
      shadow     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        StIdle: begin
          slot_cnt <= '0;
          dig_idx  <= '0;
          if (run) begin
            state      <= StScan;
            shadow     <= value;
            frame_tick <= 1'b1;
          end
        end
        StScan: begin
          if (!run) begin
            // Abandon the slot at once; shadow is kept but goes dark.
            state    <= StIdle;
            slot_cnt <= '0;
            dig_idx  <= '0;
          end else if (slot_cnt == SlotLast) begin
            slot_cnt <= '0;
            if (dig_idx == LastIdx) begin
              dig_idx    <= '0;
              shadow     <= value;
              frame_tick <= 1'b1;
            end else begin
              dig_idx <= dig_idx + 4'd1;
            end
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // upper_zero[i]: shadow nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (shadow[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (shadow[4*i +: 4] == 4'h0);
    end
  end

  // Nibble select and leading-zero suppression for the current digit. Digit 0 is never
  // suppressed.
  always_comb begin
    nibble = 4'h0;
    supp   = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (dig_idx == 4'(i)) begin
        nibble = shadow[4*i +: 4];
        if (i != 0) supp = upper_zero[i];
      end
    end
    supp = supp && blank_lz;
  end

  // A zero-length blank makes the comparison trivially true; keep it out of the logic.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign past_blank = 1'b1;
  end else begin : g_blank
    assign past_blank = (slot_cnt >= BlankVal);
  end

  // Enable only while scanning, after the blanking interval, and for unsuppressed digits.
  always_comb begin
    dig_en = (state == StScan) && past_blank && !supp;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl. The main instance uses a small
// prescale. Two extra instances cover zero blanking and a single digit.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  dig_idx;
  logic        dig_en;
  logic [3:0]  nibble;
  logic        frame_tick;

  logic        run_b;
  logic        blank_b;
  logic [15:0] value_b0;
  logic [3:0]  value_n1;
  logic [3:0]  b0_idx, b0_nib, n1_idx, n1_nib;
  logic        b0_en, b0_ft, n1_en, n1_ft;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .value(value), .blank_lz(blank_lz),
    .dig_idx(dig_idx), .dig_en(dig_en), .nibble(nibble), .frame_tick(frame_tick)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .run(run_b), .value(value_b0), .blank_lz(blank_b),
    .dig_idx(b0_idx), .dig_en(b0_en), .nibble(b0_nib), .frame_tick(b0_ft)
  );

  seg_scan_ctrl #(.NUM_DIGITS(1), .PRESCALE(8), .BLANK_CYCLES(2)) u_n1 (
    .clk(clk), .rst_n(rst_n), .run(run_b), .value(value_n1), .blank_lz(blank_b),
    .dig_idx(n1_idx), .dig_en(n1_en), .nibble(n1_nib), .frame_tick(n1_ft)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          idx, cnt;
  logic [15:0] ev, sh;
  logic        exp_en;

  initial begin
    rst_n    = 1'b0;
    run      = 1'b0;
    value    = 16'h0;
    blank_lz = 1'b0;
    run_b    = 1'b0;
    blank_b  = 1'b0;
    value_b0 = 16'h3A5C;
    value_n1 = 4'h7;

    // Reset and idle
    #12;
    check_eq("rst_hold", {dig_idx, dig_en, nibble, frame_tick}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq("idle", {dig_idx, dig_en, nibble, frame_tick}, 32'h0);
    end

    // Basic scan, with the value changed at cycle 12 of the second frame
    value = 16'h3A5C;
    run   = 1'b1;
    for (int c = 0; c < 116; c++) begin
      @(negedge clk);
      idx = (c / 8) % 4;
      cnt = c % 8;
      ev  = (c < 64) ? 16'h3A5C : 16'h1111;
      sh  = ev >> (4 * idx);
      check_eq("scan_idx", dig_idx, idx);
      check_eq("scan_tick", frame_tick, (c % 32) == 0);
      check_eq("scan_en", dig_en, cnt >= 2);
      check_eq("scan_nib", nibble, sh[3:0]);
      if (c == 44) value = 16'h1111;
    end

    // Stop during slot 2 (cycle 115 is slot 2, count 3)
    run = 1'b0;
    @(negedge clk);
    check_eq("stop_en", dig_en, 1'b0);
    check_eq("stop_idx", dig_idx, 4'd0);
    check_eq("stop_tick", frame_tick, 1'b0);
    check_eq("stop_nib", nibble, 4'h1);

    // Restart with leading-zero suppression: 0040 then 0000
    value    = 16'h0040;
    blank_lz = 1'b1;
    run      = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      idx    = (c / 8) % 4;
      cnt    = c % 8;
      ev     = (c < 32) ? 16'h0040 : 16'h0000;
      sh     = ev >> (4 * idx);
      exp_en = (cnt >= 2) && ((c < 32) ? (idx <= 1) : (idx == 0));
      check_eq("lz_idx", dig_idx, idx);
      check_eq("lz_tick", frame_tick, (c % 32) == 0);
      check_eq("lz_en", dig_en, exp_en);
      check_eq("lz_nib", nibble, sh[3:0]);
      if (c == 5) value = 16'h0000;
    end

    // Asynchronous reset while a digit is lit
    blank_lz = 1'b0;
    value    = 16'h3A5C;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_en", dig_en, 1'b1);
    check_eq("pre_rst_nib", nibble, 4'hC);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst", {dig_idx, dig_en, nibble, frame_tick}, 32'h0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", {dig_idx, dig_en, nibble, frame_tick}, 32'h0);

    // Boundaries: zero blanking, and a single digit
    run_b = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idx = (c / 8) % 4;
      cnt = c % 8;
      sh  = 16'h3A5C >> (4 * idx);
      check_eq("b0_en", b0_en, 1'b1);
      check_eq("b0_idx", b0_idx, idx);
      check_eq("b0_tick", b0_ft, (c % 32) == 0);
      check_eq("b0_nib", b0_nib, sh[3:0]);
      check_eq("n1_tick", n1_ft, cnt == 0);
      check_eq("n1_idx", n1_idx, 4'd0);
      check_eq("n1_en", n1_en, cnt >= 2);
      check_eq("n1_nib", n1_nib, 4'h7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed digit scanner for the multi-digit 7-segment display path.
- Sits directly upstream of the 4-to-16 digit decoder: drives its 4-bit select and enable, which produce the one-hot digit strobes.
- Presents the selected hex nibble to the segment encoder.
- Adds a blanking interval between digits to prevent ghosting, optional leading-zero suppression, and a frame-coherent value snapshot.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..16.
- PRESCALE, 50000, clock cycles per digit slot; must be > BLANK_CYCLES and >= 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with dig_en held low; legal range 0..PRESCALE-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  1 = scan, 0 = idle/dark.
- value  input  4*NUM_DIGITS  hex digits; nibble i = value[4i+3:4i], digit 0 = least significant.
- blank_lz  input  1  1 = suppress leading zeros.
- dig_idx  output  4  digit select to decoder "in".
- dig_en  output  1  digit enable to decoder "enable".
- nibble  output  4  hex code of current digit to segment encoder.
- frame_tick  output  1  one-cycle pulse at each frame start.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously clears all state: state=IDLE, slot_cnt=0, dig_idx=0, shadow=0, frame_tick=0. This gives dig_en=0 and nibble=0.
- Registered state:
  - state: IDLE or SCAN.
  - slot_cnt: clog2(PRESCALE) bits.
  - dig_idx: 4 bits.
  - shadow: 4*NUM_DIGITS bits.
  - frame_tick register.
- Output paths:
  - dig_en and nibble are combinational functions of registers only.
  - No input-to-output combinational path.
- IDLE:
  - slot_cnt=0, dig_idx=0, dig_en=0.
  - On the first edge with run=1: go to SCAN, slot_cnt=0, dig_idx=0, shadow<=value, frame_tick<=1.
- SCAN, each edge:
  - slot_cnt increments.
  - At slot_cnt=PRESCALE-1: slot_cnt<=0 and dig_idx advances.
  - Wrap: if dig_idx=NUM_DIGITS-1, then dig_idx<=0, shadow<=value, frame_tick<=1.
  - frame_tick is 0 on all other edges.
- Timing:
  - Frame length = NUM_DIGITS*PRESCALE cycles.
  - frame_tick high coincides with dig_idx=0, slot_cnt=0.
- run deasserted in SCAN:
  - Next edge returns to IDLE; counters clear; dig_en low from that edge.
  - No partial-slot completion.
  - shadow is retained but not displayed.
- Outputs:
  - nibble = shadow[4*dig_idx +: 4].
  - dig_en = (state==SCAN) && (slot_cnt >= BLANK_CYCLES) && !supp.
  - With BLANK_CYCLES=0, dig_en is high for the whole slot.
- Suppression:
  - supp = blank_lz && (dig_idx != 0) && (shadow nibbles dig_idx..NUM_DIGITS-1 all zero).
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - blank_lz is used live, not snapshotted.
- Coherency:
  - value changes mid-frame do not affect the display until the next frame start.
- Width rules:
  - dig_idx never exceeds NUM_DIGITS-1.
  - Unused upper dig_idx codes are never driven.
- Edge case NUM_DIGITS=1:
  - dig_idx stays 0.
  - Wrap (snapshot plus frame_tick) occurs every PRESCALE cycles.

Test Plan:
- Reset/idle: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2. Hold rst_n=0, then release with run=0 for 20 cycles -> dig_idx=0, dig_en=0, nibble=0, frame_tick=0 throughout.
- Basic scan: value=16'h3A5C, run=1, blank_lz=0 -> frame_tick pulses every 32 cycles. dig_idx steps 0,1,2,3 every 8 cycles. nibble = C,5,A,3 per slot. dig_en low for slot_cnt 0–1 and high for 2–7 in each slot.
- Snapshot: change value to 16'h1111 at cycle 12 of a frame -> display remains 3A5C until the next frame_tick, then shows 1111.
- Leading zeros: value=16'h0040, blank_lz=1 -> dig_en never asserts in slots 3 and 2; asserts in slot 1 (nibble=4) and slot 0 (nibble=0). With value=0, only slot 0 is enabled.
- Mid-operation stop/reset:
  - Drop run during slot 2 -> next edge: dig_en=0, dig_idx=0. Reassert run -> frame_tick is immediate, and scan restarts at digit 0.
  - Pulse rst_n low mid-slot -> outputs clear asynchronously, without waiting for a clock edge.
- Boundaries: BLANK_CYCLES=0 -> dig_en is continuously high during SCAN with blank_lz=0. NUM_DIGITS=1 -> frame_tick every 8 cycles and dig_idx stays 0.
